// File: rtl/axis_pkg.sv
// axis_pkg: shared AXI-stream constants (default byte width, keep masks).
package axis_pkg;
    localparam int DEF_BYTE_WIDTH = 8;
    localparam logic [1:0] KEEP_LO = 2'b01;
    localparam logic [1:0] KEEP_ALL = 2'b11;
endpackage

// File: rtl/axis_pack16.sv
// axis_pack16: packs pairs of stream bytes into 2-byte words, first byte low.
// Define AXIS_PACK16_LAST_EN to add ilast/olast/okeep for partial final words.
module axis_pack16 import axis_pkg::*; #(
    parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [BYTE_WIDTH-1:0]   idata,
    input  logic                    ivalid,
    output logic                    iready,
`ifdef AXIS_PACK16_LAST_EN
    input  logic                    ilast,
    output logic                    olast,
    output logic [1:0]              okeep,
`endif
    output logic [2*BYTE_WIDTH-1:0] odata,
    output logic                    ovalid,
    input  logic                    oready,
    output logic [1:0]              size
);
    logic                  lo_valid;
    logic [BYTE_WIDTH-1:0] lo;
    logic                  fin;
    logic                  load;
`ifdef AXIS_PACK16_LAST_EN
    // a last byte with no partner closes a word just like a second byte
    assign fin = lo_valid || ilast;
`else
    assign fin = lo_valid;
`endif
    assign iready = !fin || !ovalid || oready;
    assign load   = ivalid && iready && fin;
    assign size   = {ovalid, lo_valid};
    always_ff @(posedge clock) begin
        if (reset) begin
            lo_valid <= 1'b0;
            lo       <= '0;
            ovalid   <= 1'b0;
            odata    <= '0;
`ifdef AXIS_PACK16_LAST_EN
            olast    <= 1'b0;
            okeep    <= '0;
`endif
        end else if (load) begin
            odata    <= lo_valid ? {idata, lo} : {{BYTE_WIDTH{1'b0}}, idata};
            ovalid   <= 1'b1;
            lo_valid <= 1'b0;
`ifdef AXIS_PACK16_LAST_EN
            olast    <= ilast;
            okeep    <= lo_valid ? KEEP_ALL : KEEP_LO;
`endif
        end else begin
            if (ovalid && oready)
                ovalid <= 1'b0;
            if (ivalid && iready) begin
                lo       <= idata;
                lo_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_pack16.sv
// tb_axis_pack16: randomized scoreboard bench for axis_pack16 (default or AXIS_PACK16_LAST_EN build).
module tb_axis_pack16;
    import axis_pkg::*;
`ifdef AXIS_PACK16_LAST_EN
    localparam bit LAST = 1'b1;
    logic       olast;
    logic [1:0] okeep;
`else
    localparam bit LAST = 1'b0;
`endif
    typedef struct {logic [15:0] d; logic [1:0] k; logic l;} word_t;

    logic        clock = 1'b0, reset = 1'b1, ivalid = 1'b0, oready = 1'b0, ilast = 1'b0;
    logic [7:0]  idata = '0;
    logic        iready, ovalid;
    logic [15:0] odata;
    logic [1:0]  size;
    word_t       wq[$];
    logic [7:0]  bq[$];
    int          tests = 0, fails = 0;

    always #5 clock = ~clock;

    axis_pack16 #(.BYTE_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .idata(idata), .ivalid(ivalid), .iready(iready),
`ifdef AXIS_PACK16_LAST_EN
        .ilast(ilast), .olast(olast), .okeep(okeep),
`endif
        .odata(odata), .ovalid(ovalid), .oready(oready), .size(size)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic l);
        ivalid = v;
        idata  = d;
        oready = r;
        ilast  = l;
        @(posedge clock);
        #1;
    endtask

    // reference: bytes pair up in arrival order; a word is held until taken downstream
    always @(negedge clock) begin
        if (reset) begin
            wq.delete();
            bq.delete();
        end else begin
            check("size", {30'd0, size}, bq.size() + 2 * wq.size());
            check("ovalid", {31'd0, ovalid}, {31'd0, wq.size() != 0});
            check("iready", {31'd0, iready},
                  {31'd0, !((bq.size() != 0 || (LAST && ilast)) && wq.size() != 0 && !oready)});
            if (ovalid && wq.size() != 0) begin
                check("odata", {16'd0, odata}, {16'd0, wq[0].d});
`ifdef AXIS_PACK16_LAST_EN
                check("okeep", {30'd0, okeep}, {30'd0, wq[0].k});
                check("olast", {31'd0, olast}, {31'd0, wq[0].l});
`endif
                if (oready) void'(wq.pop_front());
            end
            if (ivalid && iready) begin
                if (bq.size() != 0) begin
                    wq.push_back(word_t'{{idata, bq[0]}, KEEP_ALL, ilast});
                    bq.delete();
                end else if (LAST && ilast)
                    wq.push_back(word_t'{{8'h00, idata}, KEEP_LO, 1'b1});
                else
                    bq.push_back(idata);
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_size", {30'd0, size}, 0);
        check("rst_iready", {31'd0, iready}, 1);
        check("rst_ovalid", {31'd0, ovalid}, 0);
        check("rst_odata", {16'd0, odata}, 0);

        cyc(1, 8'h11, 1, 0);
        check("seq_size1", {30'd0, size}, 1);
        cyc(1, 8'h22, 1, 0);
        check("seq_ovalid", {31'd0, ovalid}, 1);
        check("seq_odata", {16'd0, odata}, 32'h2211);
        check("seq_size2", {30'd0, size}, 2);
        cyc(0, 8'h00, 1, 0);
        check("seq_size0", {30'd0, size}, 0);

        for (int i = 1; i <= 8; i++) begin
            cyc(1, 8'(i), 1, 0);
            check("stream_iready", {31'd0, iready}, 1);
        end
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);

        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        cyc(1, 8'hA3, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 8'h00, 0, 0);
            check("full_size", {30'd0, size}, 3);
            check("full_iready", {31'd0, iready}, 0);
            check("full_odata", {16'd0, odata}, 32'hA2A1);
        end
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'hA4, 1, 0);
        check("drain_odata", {16'd0, odata}, 32'hA4A3);
        cyc(0, 8'h00, 1, 0);
        check("drain_size", {30'd0, size}, 0);

        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        cyc(1, 8'hA3, 0, 0);
        ivalid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("midrst_size", {30'd0, size}, 0);
        check("midrst_ovalid", {31'd0, ovalid}, 0);
        oready = 1'b1;
        repeat (3) cyc(0, 8'h00, 1, 0);

`ifdef AXIS_PACK16_LAST_EN
        cyc(1, 8'h55, 1, 1);
        check("last1_odata", {16'd0, odata}, 32'h0055);
        check("last1_okeep", {30'd0, okeep}, {30'd0, KEEP_LO});
        check("last1_olast", {31'd0, olast}, 1);
        cyc(1, 8'h66, 1, 0);
        cyc(1, 8'h77, 1, 1);
        check("last2_odata", {16'd0, odata}, 32'h7766);
        check("last2_okeep", {30'd0, okeep}, {30'd0, KEEP_ALL});
        check("last2_olast", {31'd0, olast}, 1);
        cyc(0, 8'h00, 1, 0);
`endif

        for (int i = 0; i < 10000; i++)
            cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, LAST && (($urandom % 4) == 0));
        repeat (4) cyc(0, 8'h00, 1, 0);
        check("end_pending", {30'd0, size}, {30'd0, 2'(bq.size())});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_pack16.md
AXIS_PACK16 -- requirements
Module: axis_pack16

Interface
REQ-001 The module SHALL have parameter BYTE_WIDTH, default 8, giving the input byte width; the output word width SHALL be 2*BYTE_WIDTH.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 idata  input  BYTE_WIDTH  upstream byte.
REQ-005 ivalid  input  1  upstream byte valid.
REQ-006 iready  output  1  upstream byte accepted when ivalid && iready.
REQ-007 odata  output  2*BYTE_WIDTH  packed word; first byte in [BYTE_WIDTH-1:0], second byte in the upper half.
REQ-008 ovalid  output  1  packed word valid.
REQ-009 oready  input  1  downstream accepts the word when ovalid && oready.
REQ-010 size  output  2  number of bytes held (0..3).

Function
REQ-011 State SHALL be lo_valid (low byte held), the lo register, and the output register (odata, ovalid).
REQ-012 iready SHALL equal !lo_valid || !ovalid || oready, purely combinational from state and oready.
REQ-013 An input transfer with !lo_valid SHALL store idata in lo and set lo_valid; ovalid/odata are unaffected except by REQ-015.
REQ-014 An input transfer with lo_valid SHALL load odata <= {idata, lo}, set ovalid, and clear lo_valid, in the same edge.
REQ-015 An output transfer without a simultaneous load (REQ-014) SHALL clear ovalid; a simultaneous output transfer and load SHALL leave ovalid=1 with the new word.
REQ-016 odata SHALL hold stable while ovalid && !oready; ovalid SHALL never drop without a transfer.
REQ-017 size SHALL equal lo_valid + 2*ovalid, and size(t+1) SHALL equal size(t) + (ivalid&&iready) - 2*(ovalid&&oready).
REQ-018 Sustained throughput SHALL be one byte per cycle with oready held high; latency from second byte accepted to ovalid is one cycle.
REQ-019 Byte order SHALL be preserved: the k-th accepted byte appears in word k/2, half k%2.

Reset
REQ-020 On reset, lo_valid=0, ovalid=0, odata=0, lo=0, so size=0 and iready=1 in the following cycle.
REQ-021 Reset mid-operation SHALL discard any held low byte and pending word without emitting them.

Configuration
REQ-022 Macro AXIS_PACK16_LAST_EN, when defined, SHALL add ports ilast (input, 1), olast (output, 1), okeep (output, 2).
REQ-023 With AXIS_PACK16_LAST_EN, a transfer with ilast when !lo_valid SHALL emit a word immediately with upper half 0, okeep=2'b01, olast=1 (subject to the same iready/REQ-014 rules as a second byte).
REQ-024 With AXIS_PACK16_LAST_EN, a full word SHALL carry okeep=2'b11 and olast = ilast of its second byte; okeep and olast reset to 0.
REQ-025 Without AXIS_PACK16_LAST_EN, the extra ports SHALL be absent and every word is implicitly full.

Structure
REQ-026 A shared package axis_pkg SHALL hold the default BYTE_WIDTH constant and the keep-mask constants KEEP_LO=2'b01 and KEEP_ALL=2'b11.
REQ-027 The module SHALL be flat; no sub-module is required.

Verification
REQ-028 Reset then bytes 0x11,0x22 with oready=1 -> odata=0x2211, ovalid=1 one cycle after 0x22 accepted; size sequence 0,1,2,0.
REQ-029 Continuous bytes 0x01..0x08, oready=1 -> words 0x0201,0x0403,0x0605,0x0807 on alternate cycles; iready stays 1.
REQ-030 oready=0 after 3 bytes 0xA1,0xA2,0xA3 -> size=3, iready=0, odata=0xA2A1 stable; raising oready drains with no loss.
REQ-031 Reset asserted with size=3 -> next cycle size=0, ovalid=0; no word 0xA2A1 ever emitted afterwards.
REQ-032 With AXIS_PACK16_LAST_EN: byte 0x55 with ilast=1 -> odata=0x0055, okeep=2'b01, olast=1; next bytes 0x66,0x77 (ilast on 0x77) -> 0x7766, okeep=2'b11, olast=1.
REQ-033 Random ivalid/oready for 10000 cycles -> REQ-016, REQ-017, REQ-019 hold against a byte-queue scoreboard.
